// File: rtl/div_unit_ctrl.sv
// div_unit_ctrl
// Sequencing controller wrapped around the shared unsigned sequential divider
// core used by RV32M DIV/DIVU/REM/REMU. Requests arrive over a valid/ready
// handshake. Divide-by-zero and signed overflow are answered locally without
// touching the core. Every other request is converted to unsigned magnitudes,
// run through the core, and then sign corrected. The result is returned with
// the destination tag of the request.
module div_unit_ctrl #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic [TAG_W-1:0] req_tag,
  input  logic             flush,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             core_start,
  output logic [WIDTH-1:0] core_dividend,
  output logic [WIDTH-1:0] core_divisor,
  input  logic             core_busy,
  input  logic [WIDTH-1:0] core_quotient,
  input  logic [WIDTH-1:0] core_remainder
);

  // Constants for two's complement negation and for the one signed value
  // that has no positive counterpart.
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ALL_ONE = {WIDTH{1'b1}};

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LAUNCH = 3'd1,
    ARM    = 3'd2,
    RUN    = 3'd3,
    DONE   = 3'd4,
    DRAIN  = 3'd5
  } state_t;

  state_t state_q;

  // Registered handshake and start outputs, updated together with the state.
  logic reqReady_q;
  logic rspValid_q;
  logic coreStart_q;

  // Per-operation context captured when a request is accepted.
  logic             isRem_q,     isRem_d;
  logic             signA_q,     signA_d;
  logic             signB_q,     signB_d;
  logic             seenBusy_q,  seenBusy_d;
  logic [TAG_W-1:0] rspTag_q,    rspTag_d;
  logic [WIDTH-1:0] rspData_q,   rspData_d;
  logic [WIDTH-1:0] dividend_q,  dividend_d;
  logic [WIDTH-1:0] divisor_q,   divisor_d;

  // Request decode signals.
  logic             reqSigned;
  logic             reqSignA;
  logic             reqSignB;
  logic [WIDTH-1:0] magA;
  logic [WIDTH-1:0] magB;
  logic             divByZero;
  logic             signedOverflow;
  logic             isSpecial;
  logic [WIDTH-1:0] specialQuot;
  logic [WIDTH-1:0] specialRem;
  logic [WIDTH-1:0] specialData;
  logic             accept;

  // Core result after sign correction.
  logic [WIDTH-1:0] fixedQuot;
  logic [WIDTH-1:0] fixedRem;
  logic [WIDTH-1:0] coreResult;
  logic             runDone;

  // Decode the incoming request. This covers signs, magnitudes, special
  // cases, and the acceptance condition.
  always_comb begin
    reqSigned      = ~req_op[0];
    reqSignA       = reqSigned & req_a[WIDTH-1];
    reqSignB       = reqSigned & req_b[WIDTH-1];
    magA           = reqSignA ? (~req_a + ONE) : req_a;
    magB           = reqSignB ? (~req_b + ONE) : req_b;
    divByZero      = (req_b == '0);
    signedOverflow = reqSigned & (req_a == MIN_NEG) & (req_b == ALL_ONE);
    isSpecial      = divByZero | signedOverflow;
    specialQuot    = divByZero ? ALL_ONE : req_a;
    specialRem     = divByZero ? req_a : '0;
    specialData    = req_op[1] ? specialRem : specialQuot;
    accept         = req_valid & (state_q == IDLE) & ~flush;
  end

  // Apply sign correction to the core outputs. The quotient takes the sign
  // of a^b and the remainder takes the sign of the dividend.
  always_comb begin
    fixedQuot  = (signA_q ^ signB_q) ? (~core_quotient + ONE) : core_quotient;
    fixedRem   = signA_q ? (~core_remainder + ONE) : core_remainder;
    coreResult = isRem_q ? fixedRem : fixedQuot;
    runDone    = (state_q == RUN) & ~flush & ~core_busy;
  end

  // Compute the next value of the datapath registers. Context is captured on
  // acceptance. The result is captured when the core finishes in RUN.
  // seenBusy records that the launched operation has really reached the core.
  always_comb begin
    isRem_d    = isRem_q;
    signA_d    = signA_q;
    signB_d    = signB_q;
    seenBusy_d = seenBusy_q;
    rspTag_d   = rspTag_q;
    rspData_d  = rspData_q;
    dividend_d = dividend_q;
    divisor_d  = divisor_q;
    if (accept) begin
      isRem_d    = req_op[1];
      signA_d    = reqSignA;
      signB_d    = reqSignB;
      seenBusy_d = 1'b0;
      rspTag_d   = req_tag;
      if (isSpecial) begin
        rspData_d = specialData;
      end else begin
        dividend_d = magA;
        divisor_d  = magB;
      end
    end else begin
      if (runDone) begin
        rspData_d = coreResult;
      end
      if (core_busy && ((state_q == ARM) || (state_q == RUN) || (state_q == DRAIN))) begin
        seenBusy_d = 1'b1;
      end
    end
  end

  // Datapath registers. The core operands stay untouched between launch and
  // completion, so they remain stable for the whole core run.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      isRem_q    <= 1'b0;
      signA_q    <= 1'b0;
      signB_q    <= 1'b0;
      seenBusy_q <= 1'b0;
      rspTag_q   <= '0;
      rspData_q  <= '0;
      dividend_q <= '0;
      divisor_q  <= '0;
    end else begin
      isRem_q    <= isRem_d;
      signA_q    <= signA_d;
      signB_q    <= signB_d;
      seenBusy_q <= seenBusy_d;
      rspTag_q   <= rspTag_d;
      rspData_q  <= rspData_d;
      dividend_q <= dividend_d;
      divisor_q  <= divisor_d;
    end
  end

  // Control FSM with registered req_ready, rsp_valid and core_start.
  // A flush while the core may be running goes to DRAIN. DRAIN waits for
  // the core to finish, because the core cannot be aborted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      reqReady_q  <= 1'b1;
      rspValid_q  <= 1'b0;
      coreStart_q <= 1'b0;
    end else begin
      coreStart_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            reqReady_q <= 1'b0;
            if (isSpecial) begin
              state_q    <= DONE;
              rspValid_q <= 1'b1;
            end else begin
              state_q     <= LAUNCH;
              coreStart_q <= 1'b1;
            end
          end
        end
        LAUNCH: begin
          state_q <= flush ? DRAIN : ARM;
        end
        ARM: begin
          if (flush) begin
            state_q <= DRAIN;
          end else if (core_busy) begin
            state_q <= RUN;
          end
        end
        RUN: begin
          if (flush) begin
            state_q <= DRAIN;
          end else if (runDone) begin
            state_q    <= DONE;
            rspValid_q <= 1'b1;
          end
        end
        DONE: begin
          if (flush || rsp_ready) begin
            state_q    <= IDLE;
            rspValid_q <= 1'b0;
            reqReady_q <= 1'b1;
          end
        end
        DRAIN: begin
          if (seenBusy_q && !core_busy) begin
            state_q    <= IDLE;
            reqReady_q <= 1'b1;
          end
        end
        default: begin
          state_q    <= IDLE;
          reqReady_q <= 1'b1;
          rspValid_q <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready     = reqReady_q;
  assign rsp_valid     = rspValid_q;
  assign rsp_data      = rspData_q;
  assign rsp_tag       = rspTag_q;
  assign core_start    = coreStart_q;
  assign core_dividend = dividend_q;
  assign core_divisor  = divisor_q;

endmodule

// File: tb/tb_div_unit_ctrl.sv
// tb_div_unit_ctrl
// Directed bench for div_unit_ctrl. The divider core is modelled with a fixed
// busy duration. Expected responses are queued as requests are accepted, and
// a monitor compares them on every response handshake.
module tb_div_unit_ctrl;

  localparam int WIDTH    = 32;
  localparam int TAG_W    = 5;
  localparam int CORE_LAT = 6;

  localparam logic [1:0] OP_DIV  = 2'd0;
  localparam logic [1:0] OP_DIVU = 2'd1;
  localparam logic [1:0] OP_REM  = 2'd2;
  localparam logic [1:0] OP_REMU = 2'd3;

  logic             clk = 1'b0;
  logic             rst;
  logic             req_valid;
  logic             req_ready;
  logic [1:0]       req_op;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;
  logic [TAG_W-1:0] req_tag;
  logic             flush;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_data;
  logic [TAG_W-1:0] rsp_tag;
  logic             core_start;
  logic [WIDTH-1:0] core_dividend;
  logic [WIDTH-1:0] core_divisor;
  logic             coreBusy;
  logic [WIDTH-1:0] coreQ;
  logic [WIDTH-1:0] coreR;

  logic [WIDTH-1:0] dvdReg;
  logic [WIDTH-1:0] dvsReg;
  int               coreCnt;
  int               startCount = 0;
  int               startWhileBusy = 0;

  int total = 0;
  int bad   = 0;

  logic [WIDTH-1:0] expDataQ[$];
  logic [TAG_W-1:0] expTagQ[$];

  div_unit_ctrl #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_op         (req_op),
    .req_a          (req_a),
    .req_b          (req_b),
    .req_tag        (req_tag),
    .flush          (flush),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_data       (rsp_data),
    .rsp_tag        (rsp_tag),
    .core_start     (core_start),
    .core_dividend  (core_dividend),
    .core_divisor   (core_divisor),
    .core_busy      (coreBusy),
    .core_quotient  (coreQ),
    .core_remainder (coreR)
  );

  always #5 clk = ~clk;

  // Divider core model. The core samples start, raises busy on the next
  // cycle, and drops busy with results valid after CORE_LAT+1 busy cycles.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      coreBusy <= 1'b0;
      coreCnt  <= 0;
      coreQ    <= '0;
      coreR    <= '0;
      dvdReg   <= '0;
      dvsReg   <= '0;
    end else if (coreBusy) begin
      if (coreCnt == 0) begin
        coreBusy <= 1'b0;
        coreQ    <= (dvsReg == '0) ? '1 : dvdReg / dvsReg;
        coreR    <= (dvsReg == '0) ? dvdReg : dvdReg % dvsReg;
      end else begin
        coreCnt <= coreCnt - 1;
      end
    end else if (core_start) begin
      coreBusy   <= 1'b1;
      coreCnt    <= CORE_LAT;
      dvdReg     <= core_dividend;
      dvsReg     <= core_divisor;
      startCount <= startCount + 1;
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Response monitor. It pops the expected response on each handshake and
  // counts any start pulse issued while the core is busy.
  always @(negedge clk) begin : monitor
    logic [WIDTH-1:0] d;
    logic [TAG_W-1:0] t;
    if (rst && rsp_valid && rsp_ready) begin
      if (expDataQ.size() == 0) begin
        checkOutput("unexpected_rsp", 64'd1, 64'd0);
      end else begin
        d = expDataQ.pop_front();
        t = expTagQ.pop_front();
        checkOutput("rsp_data", 64'(rsp_data), 64'(d));
        checkOutput("rsp_tag", 64'(rsp_tag), 64'(t));
      end
    end
    if (rst && core_start && coreBusy) startWhileBusy++;
  end

  task automatic applyStimulus(input logic [1:0] op, input logic [WIDTH-1:0] a,
                               input logic [WIDTH-1:0] b, input logic [TAG_W-1:0] tag,
                               input bit push, input logic [WIDTH-1:0] exp);
    bit accepted;
    accepted = 1'b0;
    req_valid = 1'b1;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    req_tag   = tag;
    for (int i = 0; i < 200 && !accepted; i++) begin
      @(negedge clk);
      accepted = req_ready && !flush;
      @(posedge clk);
      #1;
    end
    req_valid = 1'b0;
    if (!accepted) checkOutput("accept_timeout", 64'd0, 64'd1);
    else if (push) begin
      expDataQ.push_back(exp);
      expTagQ.push_back(tag);
    end
  endtask

  task automatic waitIdle(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      ok = req_ready;
    end
    if (!ok) checkOutput(name, 64'd0, 64'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic waitBusy(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = coreBusy;
    end
    if (!ok) checkOutput(name, 64'd0, 64'd1);
  endtask

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    int s0;
    bit seen;
    rst       = 1'b0;
    req_valid = 1'b0;
    req_op    = '0;
    req_a     = '0;
    req_b     = '0;
    req_tag   = '0;
    flush     = 1'b0;
    rsp_ready = 1'b1;

    repeat (2) @(negedge clk);
    checkOutput("reset_req_ready", 64'(req_ready), 64'd1);
    checkOutput("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    checkOutput("reset_core_start", 64'(core_start), 64'd0);
    checkOutput("reset_rsp_data", 64'(rsp_data), 64'd0);
    checkOutput("reset_rsp_tag", 64'(rsp_tag), 64'd0);
    checkOutput("reset_core_dividend", 64'(core_dividend), 64'd0);
    checkOutput("reset_core_divisor", 64'(core_divisor), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] signed divide and remainder");
    applyStimulus(OP_DIV, 32'hFFFFFFF9, 32'd2, 5'd1, 1'b1, 32'hFFFFFFFD);
    waitIdle("idle_div_neg7");
    checkOutput("core_dividend_mag", 64'(dvdReg), 64'd7);
    checkOutput("core_divisor_mag", 64'(dvsReg), 64'd2);
    applyStimulus(OP_REM, 32'hFFFFFFF9, 32'd2, 5'd2, 1'b1, 32'hFFFFFFFF);
    waitIdle("idle_rem_neg7");
    applyStimulus(OP_DIV, 32'd7, 32'hFFFFFFFE, 5'd3, 1'b1, 32'hFFFFFFFD);
    waitIdle("idle_div_7_neg2");
    applyStimulus(OP_REM, 32'd7, 32'hFFFFFFFE, 5'd4, 1'b1, 32'd1);
    waitIdle("idle_rem_7_neg2");
    applyStimulus(OP_DIV, 32'h80000000, 32'd2, 5'd5, 1'b1, 32'hC0000000);
    waitIdle("idle_div_minneg_2");
    checkOutput("core_dividend_minneg", 64'(dvdReg), 64'h80000000);
    applyStimulus(OP_DIVU, 32'h80000000, 32'hFFFFFFFF, 5'd6, 1'b1, 32'd0);
    waitIdle("idle_divu_big");

    $display("[TB] special cases");
    s0 = startCount;
    applyStimulus(OP_DIVU, 32'd100, 32'd0, 5'd7, 1'b1, 32'hFFFFFFFF);
    @(negedge clk);
    checkOutput("div0_latency", 64'(rsp_valid), 64'd1);
    waitIdle("idle_divu_zero");
    applyStimulus(OP_REMU, 32'd100, 32'd0, 5'd8, 1'b1, 32'd100);
    waitIdle("idle_remu_zero");
    applyStimulus(OP_DIV, 32'h80000000, 32'hFFFFFFFF, 5'd9, 1'b1, 32'h80000000);
    @(negedge clk);
    checkOutput("ovf_latency", 64'(rsp_valid), 64'd1);
    waitIdle("idle_div_ovf");
    applyStimulus(OP_REM, 32'h80000000, 32'hFFFFFFFF, 5'd10, 1'b1, 32'd0);
    waitIdle("idle_rem_ovf");
    checkOutput("special_no_start", 64'(startCount), 64'(s0));

    $display("[TB] response back-pressure");
    rsp_ready = 1'b0;
    applyStimulus(OP_DIVU, 32'hFFFFFFFF, 32'd16, 5'd11, 1'b1, 32'h0FFFFFFF);
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      seen = rsp_valid;
    end
    if (!seen) checkOutput("hold_rsp_timeout", 64'd0, 64'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("hold_valid", 64'(rsp_valid), 64'd1);
      checkOutput("hold_data", 64'(rsp_data), 64'h0FFFFFFF);
      checkOutput("hold_tag", 64'(rsp_tag), 64'd11);
    end
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    waitIdle("idle_hold");

    $display("[TB] flush while idle with a request present");
    s0 = startCount;
    req_valid = 1'b1;
    req_op    = OP_DIVU;
    req_a     = 32'd5;
    req_b     = 32'd1;
    req_tag   = 5'd12;
    flush     = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("flush_idle_ready", 64'(req_ready), 64'd1);
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    flush     = 1'b0;
    checkOutput("flush_idle_no_start", 64'(startCount), 64'(s0));

    $display("[TB] flush in launch");
    s0 = startCount;
    applyStimulus(OP_DIVU, 32'd50, 32'd5, 5'd13, 1'b0, 32'd0);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    waitIdle("idle_flush_launch");
    checkOutput("flush_launch_start", 64'(startCount), 64'(s0 + 1));

    $display("[TB] flush in run");
    applyStimulus(OP_DIV, 32'd1000, 32'd3, 5'd14, 1'b0, 32'd0);
    waitBusy("run_busy_timeout");
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    for (int i = 0; i < 50 && coreBusy; i++) begin
      @(negedge clk);
      if (coreBusy) begin
        checkOutput("drain_ready", 64'(req_ready), 64'd0);
        checkOutput("drain_valid", 64'(rsp_valid), 64'd0);
      end
    end
    waitIdle("idle_drain");
    applyStimulus(OP_DIVU, 32'd9, 32'd3, 5'd15, 1'b1, 32'd3);
    waitIdle("idle_after_drain");

    $display("[TB] reset during run");
    applyStimulus(OP_REMU, 32'd1000, 32'd7, 5'd16, 1'b0, 32'd0);
    waitBusy("reset_busy_timeout");
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    checkOutput("midrun_reset_valid", 64'(rsp_valid), 64'd0);
    checkOutput("midrun_reset_ready", 64'(req_ready), 64'd1);
    checkOutput("midrun_reset_start", 64'(core_start), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    applyStimulus(OP_REMU, 32'd10, 32'd4, 5'd17, 1'b1, 32'd2);
    waitIdle("idle_after_reset");

    repeat (2) @(negedge clk);
    checkOutput("pending_responses", 64'(expDataQ.size()), 64'd0);
    checkOutput("start_while_busy", 64'(startWhileBusy), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/div_unit_ctrl.md
Name: div_unit_ctrl

Overview:
- Sequencing controller for the shared unsigned sequential divider core in the RV32M execute path.
- Accepts DIV/DIVU/REM/REMU requests over a valid/ready handshake and resolves divide-by-zero and signed overflow locally, without starting the core.
- For all other requests it converts signed operands to magnitudes, starts the core, waits for completion, applies sign correction and returns a tagged result.
- Supports pipeline flush of an in-flight operation.

Parameters:
- WIDTH, 32, operand/result width; must match the divider core.
- TAG_W, 5, width of the destination tag carried through unchanged.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset; 0 resets the block immediately.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request.
- req_op  in  2  0=DIV, 1=DIVU, 2=REM, 3=REMU.
- req_a  in  WIDTH  dividend (rs1).
- req_b  in  WIDTH  divisor (rs2).
- req_tag  in  TAG_W  destination tag.
- flush  in  1  discard any accepted, not-yet-returned operation.
- rsp_valid  out  1  result present.
- rsp_ready  in  1  consumer accepts result.
- rsp_data  out  WIDTH  quotient or remainder per op.
- rsp_tag  out  TAG_W  tag of the accepted request.
- core_start  out  1  one-cycle start pulse to the divider core.
- core_dividend, core_divisor  out  WIDTH  unsigned magnitudes, held stable from start to completion.
- core_busy  in  1  core busy flag.
- core_quotient, core_remainder  in  WIDTH  core results, valid once core_busy falls.

Behaviour:
- Reset (rst=0):
  - state=IDLE.
  - req_ready=1, rsp_valid=0, core_start=0.
  - rsp_data, rsp_tag, core_dividend and core_divisor cleared to 0.
  - Reset mid-operation abandons the core; the core has its own reset.
- States: IDLE, LAUNCH, ARM, RUN, DONE, DRAIN.
- Request acceptance:
  - req_ready = (state==IDLE).
  - A request is accepted on a cycle with req_valid & req_ready & ~flush. Op, tag, operand signs and special-case flags are latched.
- Operand signs:
  - Signed ops (0, 2): sa=a[MSB], sb=b[MSB].
  - Unsigned ops (1, 3): sa=sb=0.
  - Magnitudes are the two's complement of negative operands; -2^(WIDTH-1) maps to 2^(WIDTH-1) unsigned.
- Special cases (core never started; IDLE->DONE directly, rsp_valid on the cycle after acceptance):
  - b==0: quotient=all ones; remainder=a.
  - Signed op with a=-2^(WIDTH-1) and b=-1: quotient=a; remainder=0.
- Normal path:
  - IDLE->LAUNCH on acceptance; core operands are registered at the same time.
  - LAUNCH: core_start=1 for exactly one cycle; next state ARM.
  - ARM: wait for core_busy=1, then go to RUN. The core raises busy one cycle after sampling start.
  - RUN: on the first cycle with core_busy=0, capture the sign-corrected result into rsp_data; next state DONE.
- Sign correction:
  - Quotient is negated iff sa^sb.
  - Remainder is negated iff sa.
  - rsp_data selects the quotient for ops 0/1 and the remainder for ops 2/3.
- DONE:
  - rsp_valid=1.
  - rsp_data and rsp_tag are held stable until rsp_ready=1, then state returns to IDLE.
  - No new request is accepted in the handshake cycle.
- Flush:
  - Flush in IDLE or DONE: any pending response is dropped (rsp_valid deasserts next cycle); state becomes IDLE.
  - Flush in LAUNCH, ARM or RUN: state goes to DRAIN. The core cannot be aborted.
  - DRAIN: req_ready=0 and rsp_valid=0 until core_busy is low and a start has actually been seen busy. Then the result is discarded and state returns to IDLE.
  - Flush in LAUNCH still issues the start pulse, so the core's behaviour stays deterministic.
- Flush coinciding with req_valid in IDLE: the request is not accepted.
- Latency:
  - Special case: 1 cycle from acceptance to rsp_valid.
  - Normal case: 3 cycles plus the core busy duration.
- core_start must never be asserted while core_busy=1.

Test Plan:
- DIV a=-7 (0xFFFFFFF9), b=2: core sees 7/2 -> rsp_data=0xFFFFFFFD (-3); REM of the same operands -> 0xFFFFFFFF (-1).
- DIVU a=100, b=0 -> rsp_data=0xFFFFFFFF on the cycle after acceptance, core_start never pulses; REMU a=100, b=0 -> 100.
- DIV a=0x80000000, b=0xFFFFFFFF -> 0x80000000, no core start; REM of the same operands -> 0.
- DIVU a=0xFFFFFFFF, b=16 with rsp_ready held low 5 cycles -> rsp_valid stays 1, rsp_data=0x0FFFFFFF stable, rsp_tag unchanged until the handshake.
- DIV 1000/3 with flush asserted mid-RUN -> no rsp_valid, req_ready stays 0 until core_busy falls, then a new DIVU 9/3 returns 3.
- rst pulled low during RUN -> rsp_valid=0 and req_ready=1 immediately; after release, REMU 10/4 returns 2.
